// File: rtl/scroll_ctrl_if.sv
// Control/status bundle between the frame timing + button side and the scroll controller.
interface scroll_ctrl_if #(
  parameter int OFS_W = 10
);
  logic             frame_tick;
  logic             btn_left;
  logic             btn_right;
  logic             btn_pause;
  logic             auto_en;
  logic [2:0]       speed;
  logic [OFS_W-1:0] h_offset;
  logic             dir;
  logic             paused;
  logic             offset_upd;

  modport master (
    output frame_tick, btn_left, btn_right, btn_pause, auto_en, speed,
    input  h_offset, dir, paused, offset_upd
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_pause, auto_en, speed,
    output h_offset, dir, paused, offset_upd
  );
endinterface

// File: rtl/scroll_ctrl.sv
// Frame-rate scroll controller: button sync/debounce, RUN/PAUSED FSM and a per-frame
// wrapping horizontal offset accumulator.
module scroll_ctrl #(
  parameter int OFS_W      = 10,
  parameter int DEB_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  scroll_ctrl_if.slave bus
);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_e;

  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

  // Button bit order everywhere: 0 = left, 1 = right, 2 = pause.
  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0][3:0]  cnt_q, cnt_d;
  logic [2:0]       press;
  state_e           state_q, state_d;
  logic [OFS_W-1:0] h_offset_q, h_offset_d;
  logic             dir_q, dir_d;
  logic             upd_q, upd_d;
  logic [OFS_W-1:0] step;
  logic             left_p, right_p, pause_p;

  assign btn_raw = {bus.btn_pause, bus.btn_right, bus.btn_left};
  assign step    = OFS_W'(bus.speed);

  // Debounce counters advance only on frame_tick; a press is a 0->1 flip on that tick.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    press = '0;
    if (bus.frame_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = ~deb_q[i];
            cnt_d[i] = '0;
            press[i] = ~deb_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  assign left_p  = press[0];
  assign right_p = press[1];
  assign pause_p = press[2];

  always_comb begin
    dir_d      = dir_q;
    state_d    = state_q;
    upd_d      = 1'b0;
    h_offset_d = h_offset_q;
    if (left_p && !right_p) begin
      dir_d = 1'b1;
    end else if (right_p && !left_p) begin
      dir_d = 1'b0;
    end
    if (bus.frame_tick) begin
      case (state_q)
        RUN: begin
          if (pause_p) begin
            state_d = PAUSED;
          end else if (bus.auto_en) begin
            upd_d = 1'b1;
          end
        end
        PAUSED: begin
          if (pause_p) begin
            state_d = RUN;
          end else if (left_p ^ right_p) begin
            upd_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
    // Truncation to OFS_W bits provides wrap in both directions.
    if (upd_d) begin
      h_offset_d = dir_d ? (h_offset_q - step) : (h_offset_q + step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      state_q    <= RUN;
      h_offset_q <= '0;
      dir_q      <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      h_offset_q <= h_offset_d;
      dir_q      <= dir_d;
      upd_q      <= upd_d;
    end
  end

  assign bus.h_offset   = h_offset_q;
  assign bus.dir        = dir_q;
  assign bus.paused     = (state_q == PAUSED);
  assign bus.offset_upd = upd_q;

endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Frame-rate scroll controller feeding the scroller's pixel pipeline. Synchronizes and debounces three user buttons, runs a RUN/PAUSED state machine, and accumulates a horizontal scroll offset once per frame at the timing generator's `frame_tick`. The pixel stage consumes `h_offset`, which is stable for the whole active frame.

## Interface
- `OFS_W`, default 10: offset width; offset wraps modulo 2^OFS_W.
- `DEB_FRAMES`, default 4: consecutive `frame_tick`s a new button level must persist before it is accepted, range 1..15.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous and active-high.
- `frame_tick` in 1: single-cycle pulse at start of vblank.
- `btn_left`, `btn_right`, `btn_pause` in 1 each: raw asynchronous buttons, active-high.
- `auto_en` in 1: enables per-frame auto-scroll in RUN.
- `speed` in 3: step magnitude per frame, 0..7, sampled only on `frame_tick`.
- `h_offset` out OFS_W: current scroll offset.
- `dir` out 1: 0 = increment (scroll right), 1 = decrement.
- `paused` out 1: 1 when the FSM is in PAUSED.
- `offset_upd` out 1: one-cycle pulse, the cycle after any offset write.

## Operation
- **Sync.** Each button passes through a 2-flop synchronizer. Synchronizer flops reset to 0.
- **Debounce.** Per button there is a debounced state (reset 0) and a counter (reset 0). The counter is evaluated only on `frame_tick`:
  - synced level ≠ debounced state: counter +1. When it reaches DEB_FRAMES, the state flips and the counter clears.
  - synced level = debounced state: counter clears.
- **Press.** A press is a 0→1 flip of a debounced state. It acts on the same `frame_tick` that produced the flip. Releases have no effect.
- **Direction.** A left press sets `dir`=1; a right press sets `dir`=0. Left and right pressed on the same tick leave `dir` unchanged and count as no direction press.
- **FSM states RUN** (reset state) **and PAUSED.**
  - RUN, pause press: go to PAUSED; no offset write this tick. `dir` is still updated if a direction press is also present.
  - RUN, no pause press, `auto_en`=1: write h_offset ± speed using the new `dir`.
  - RUN, `auto_en`=0: no write.
  - PAUSED, pause press: go to RUN; no offset write this tick.
  - PAUSED, single direction press, no pause press: one step of ±speed in the new `dir` (single-step). Stay in PAUSED.
  - PAUSED otherwise: hold.
- **Arithmetic.** `speed` is zero-extended to OFS_W. The sum/difference is truncated to OFS_W bits, which gives wrap in both directions.
- **Zero speed.** `speed`=0 still counts as a write, so `offset_upd` pulses.
- **Quiet cycles.** Outside `frame_tick`, no state changes except the synchronizer flops.

## Timing
- **Reset values.** `h_offset`=0, `dir`=0, `paused`=0 (state RUN), `offset_upd`=0. Debounce states and counters are 0.
- **Reset mid-operation.** Asserting `rst` clears all registers immediately, independent of `clk`. A `frame_tick` coincident with `rst` is ignored.
- **Update latency.** `h_offset`, `dir`, `paused` and `offset_upd` are registered. They change on the `clk` edge that samples `frame_tick`=1 and are visible the following cycle. `offset_upd` is high for exactly that one cycle.
- **Button latency.** From a raw button edge to a debounced flip: 2 clk of synchronization, then DEB_FRAMES `frame_tick`s. A tick arriving before the sync completes counts the old level.
- **Back-to-back ticks.** `frame_tick` on consecutive cycles must be handled; each tick is a full evaluation.

## Test plan
1. **Auto-scroll after reset.** Release reset; `auto_en`=1, `speed`=3; 4 ticks → `h_offset` 3, 6, 9, 12, each visible one cycle after its tick; `offset_upd` pulses 4 times, each 1 cycle wide.
2. **Wrap-around (OFS_W=10).** `h_offset`=1022, `dir`=0, `speed`=3, 1 tick → 1. Then left press (`dir`=1) on a tick with `h_offset`=1 → 1022.
3. **Debounce (DEB_FRAMES=4).**
   - `btn_left` high for 3 ticks, then low → `dir` stays 0.
   - `btn_left` held high for 4 ticks → `dir`=1 on the 4th tick, and that tick's step decrements.
4. **Pause and single-step.** Starting at offset 100, `speed`=2:
   - Pause press → `paused`=1 and no write on that tick; 10 further ticks leave the offset at 100 with no `offset_upd`.
   - Right press → 102 with `offset_upd` pulse.
   - Pause press → `paused`=0, no write that tick; the next tick gives 104.
5. **Simultaneous events.**
   - Left and right pressed on the same tick with `dir`=0 → `dir` stays 0 and the offset still advances.
   - Pause and left on the same tick in RUN → PAUSED, `dir`=1, no write.
6. **Edge cases.**
   - `speed`=0 → offset constant and `offset_upd` still pulses each tick.
   - `rst` asserted mid-frame coincident with `frame_tick` → all outputs 0 immediately, no pulse.
